shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier_pkg.sv | 18 +
 rtl/shift_add_multiplier.sv | 98 +++++++++
 tb/tb_shift_add_multiplier.sv | 128 ++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared arithmetic package: FSM state encoding, counter sizing and legal
// operand-width bounds common to the sequential multiplier and divider.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential N x N shift-add multiplier, one multiplier bit per clock.
// Define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's-complement radix-2 Booth operation.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = cnt_width(N);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("shift_add_multiplier: N out of legal range");
    end

    state_t        state, next_state;
    logic [N-1:0]  m, p_hi, p_lo;
    logic [CW-1:0] count;
    logic [N:0]    sum;
    logic          accept;

    assign accept  = start && (state != RUN);
    assign product = {p_hi, p_lo};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == CW'(1)) next_state = DONE;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    logic       guard;
    logic [N:0] hi_ext, m_ext;

    // One extra adder bit keeps P_hi - M exact when M is the most negative value.
    assign hi_ext = {p_hi[N-1], p_hi};
    assign m_ext  = {m[N-1], m};

    always_comb begin
        sum = hi_ext;
        case ({p_lo[0], guard})
            2'b01:   sum = hi_ext + m_ext;
            2'b10:   sum = hi_ext - m_ext;
            default: sum = hi_ext;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          guard <= 1'b0;
        else if (accept)       guard <= 1'b0;
        else if (state == RUN) guard <= p_lo[0];
    end
`else
    assign sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);
`endif

    // sum[N] is the carry (unsigned) or the sign (Booth), shifted into P_hi's MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
        end else if (accept) begin
            m     <= multiplicand;
            p_hi  <= '0;
            p_lo  <= multiplier;
            count <= CW'(N);
        end else if (state == RUN) begin
            p_hi  <= sum[N:1];
            p_lo  <= {sum[0], p_lo[N-1:1]};
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at N=4; the signed
// vectors run when SHIFT_ADD_MULTIPLIER_SIGNED_EN is defined.
module tb_shift_add_multiplier;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    int n_chk = 0;
    int n_fail = 0;

    shift_add_multiplier #(.N(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Runs one operation; optionally pulses a 7x7 start two cycles into RUN.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic inject, input logic [7:0] exp_prod);
        int lat, bcnt;
        launch(a, b);
        chk({tag, "_acc_busy"}, 16'(busy), 16'd1);
        chk({tag, "_acc_done"}, 16'(done), 16'd0);
        lat = 0; bcnt = 1;
        while (!done && lat < 20) begin
            if (inject && lat == 1) begin
                start = 1'b1; multiplicand = 4'd7; multiplier = 4'd7;
            end else begin
                start = 1'b0; multiplicand = 4'ha; multiplier = 4'h5;
            end
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 16'(lat), 16'(N));
        chk({tag, "_busy_cycles"}, 16'(bcnt), 16'(N));
        chk({tag, "_product"}, 16'(product), 16'(exp_prod));
        repeat (2) @(posedge clock);
        #1;
        chk({tag, "_hold"}, {8'(product), 7'd0, done}, {exp_prod, 7'd0, 1'b1});
    endtask

    initial begin
        int cyc, first, second;

        #12;
        chk("rst_product", 16'(product), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
        run_op("s_m8xm8", 4'h8, 4'h8, 1'b0, 8'h40);
        run_op("s_m8x7",  4'h8, 4'h7, 1'b0, 8'hC8);
        run_op("s_m1x1",  4'hF, 4'h1, 1'b0, 8'hFF);
        run_op("s_3xm5",  4'h3, 4'hB, 1'b0, 8'hF1);
`else
        run_op("u_13x11", 4'd13, 4'd11, 1'b0, 8'h8F);
        run_op("u_15x15", 4'd15, 4'd15, 1'b0, 8'hE1);
        run_op("u_0x9",   4'd0,  4'd9,  1'b0, 8'h00);
        run_op("u_drop",  4'd13, 4'd11, 1'b1, 8'h8F);
`endif

        // Asynchronous abort mid-RUN, checked well before the next clock edge.
        launch(4'd15, 4'd15);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_product", 16'(product), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_done", 16'(done), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op("after_rst_3x5", 4'd3, 4'd5, 1'b0, 8'h0F);

        // start held high: relaunch from DONE every N+1 cycles.
        @(negedge clock);
        start = 1'b1; multiplicand = 4'd2; multiplier = 4'd6;
        cyc = 0; first = -1; second = -1;
        while (second < 0 && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (done) begin
                if (first < 0) first = cyc;
                else second = cyc;
                chk("b2b_product", 16'(product), 16'h000C);
            end
        end
        start = 1'b0;
        chk("b2b_gap", 16'(second - first), 16'(N + 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
